complex_multiplication: RTL and testbench
=========================================

Name: complex_multiplication

Overview:
- Multi-cycle signed complex multiplier: (real_a + j·image_a) × (real_b + j·image_b).
- Operands are 4-bit two's complement; the result is 8-bit two's complement.
- A single shared 4×4 signed multiplier is time-multiplexed over four cycles.
- Sits in the datapath fed by a slow operand stream. A one-cycle data_start strobe (nominally every 8 CLK cycles) marks each new operand set.

Parameters:
- None. Operand width is fixed at 4 bits and result width at 8 bits.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- data_start  input  1  operand-valid strobe; sampled on rising CLK.
- real_a  input  4  signed real part of operand A.
- image_a  input  4  signed imaginary part of operand A.
- real_b  input  4  signed real part of operand B.
- image_b  input  4  signed imaginary part of operand B.
- product_real  output  8  signed, real_a·real_b − image_a·image_b.
- product_image  output  8  signed, real_a·image_b + image_a·real_b.

Behaviour:
- Reset (RST=0, async):
  - product_real = 0, product_image = 0.
  - Operand registers, partial-product registers and the step counter = 0.
  - FSM enters IDLE.
- FSM states: IDLE, CAPTURE, MUL1, MUL2, MUL3, MUL4, OUT.
- Any state, data_start=1 at a rising edge:
  - Register all four operands.
  - Go to MUL1 (this is the capture edge, cycle 0).
  - Any calculation in progress is abandoned; outputs keep their last value.
- Shared multiplier, one product per cycle, stored sign-extended to 9 bits:
  - MUL1 (edge 1): rr = ra·rb.
  - MUL2 (edge 2): ii = ia·ib.
  - MUL3 (edge 3): ri = ra·ib.
  - MUL4 (edge 4): ir = ia·rb.
- OUT (edge 5):
  - product_real <= (rr − ii)[7:0].
  - product_image <= (ri + ir)[7:0].
  - Then return to IDLE.
- Latency: outputs update on the 5th rising edge after the capture edge, well inside the 8-cycle strobe period.
- Outputs are registered. They hold their value until the next OUT state or reset.
- Inputs are only sampled at the capture edge. Operand changes on other cycles have no effect.
- data_start held high for several cycles: each high cycle re-captures and restarts. The result appears 5 edges after the last high cycle.
- Arithmetic:
  - Products range −56..64 and must be computed full-precision (9-bit signed internally).
  - Final results wrap modulo 256 into 8-bit two's complement. The only overflow case is product_image = +128, which reads as −128 (0x80).
  - product_real range −120..120 never overflows.
- Reset asserted mid-operation: immediate clear, as above. The interrupted result is lost.
- No valid/ready output. Consumers rely on the fixed 5-cycle latency.

Test Plan:
- Reset: RST low with random inputs, data_start toggling -> product_real = 0x00, product_image = 0x00; still 0 for 5 cycles after RST rises with no strobe.
- Basic product: ra=1, ia=2, rb=3, ib=4, strobe -> 5 edges later product_real = −5 (0xFB), product_image = 10 (0x0A); both unchanged at edges 1–4.
- Extremes: all operands = −8 -> product_real = 0x00, product_image = 0x80 (wrap). Operands ra=7, ia=−8, rb=7, ib=7 -> product_real = 105 (0x69), product_image = −7 (0xF9).
- Input isolation: after capturing (1,2,3,4), change all inputs to 0 on edges 1–4 -> result still −5/10.
- Restart: strobe with (1,2,3,4), then strobe again at edge 2 with (2,0,3,0) -> no −5/10 ever appears; product_real = 6, product_image = 0 at 5 edges after the second strobe.
- Reset mid-operation: assert RST at edge 3 -> outputs 0 immediately, no result at edge 5. Strobe after release -> normal result after 5 edges.
- Sweep: drive all 65536 operand combinations through a counter every 8 cycles -> every result equals the 8-bit-wrapped mathematical value.

Source files
------------

// File: rtl/complex_multiplication.sv
// Multi-cycle signed complex multiplier: one shared 4x4 signed multiplier
// is stepped over four cycles, then the real/imaginary sums are registered.
module complex_multiplication (
  input  logic       CLK,
  input  logic       RST,
  input  logic       data_start,
  input  logic [3:0] real_a,
  input  logic [3:0] image_a,
  input  logic [3:0] real_b,
  input  logic [3:0] image_b,
  output logic [7:0] product_real,
  output logic [7:0] product_image
);

  typedef enum logic [2:0] {IDLE, CAPTURE, MUL1, MUL2, MUL3, MUL4, OUT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        ra, ia, rb, ib;
  logic [1:0]        step;
  logic signed [3:0] op_x, op_y;
  logic signed [8:0] mul, rr, ii, ri, ir, diff, sum;

  always_comb begin
    state_nxt = state;
    if (data_start) state_nxt = MUL1;
    else begin
      case (state)
        CAPTURE: state_nxt = MUL1;
        MUL1:    state_nxt = MUL2;
        MUL2:    state_nxt = MUL3;
        MUL3:    state_nxt = MUL4;
        MUL4:    state_nxt = OUT;
        OUT:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // step walks rr, ii, ri, ir in lockstep with MUL1..MUL4
  always_comb begin
    op_x = $signed(ra);
    op_y = $signed(rb);
    case (step)
      2'd1:    begin op_x = $signed(ia); op_y = $signed(ib); end
      2'd2:    begin op_x = $signed(ra); op_y = $signed(ib); end
      2'd3:    begin op_x = $signed(ia); op_y = $signed(rb); end
      default: begin op_x = $signed(ra); op_y = $signed(rb); end
    endcase
  end

  assign mul  = 9'(op_x) * 9'(op_y);
  assign diff = rr - ii;
  assign sum  = ri + ir;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      step          <= 2'd0;
      ra            <= '0;
      ia            <= '0;
      rb            <= '0;
      ib            <= '0;
      rr            <= '0;
      ii            <= '0;
      ri            <= '0;
      ir            <= '0;
      product_real  <= '0;
      product_image <= '0;
    end else begin
      state <= state_nxt;
      if (data_start) begin
        // a new strobe always wins; an in-flight result is dropped
        ra   <= real_a;
        ia   <= image_a;
        rb   <= real_b;
        ib   <= image_b;
        step <= 2'd0;
      end else begin
        case (state)
          MUL1: begin rr <= mul; step <= step + 2'd1; end
          MUL2: begin ii <= mul; step <= step + 2'd1; end
          MUL3: begin ri <= mul; step <= step + 2'd1; end
          MUL4: begin ir <= mul; step <= step + 2'd1; end
          OUT: begin
            product_real  <= diff[7:0];
            product_image <= sum[7:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_complex_multiplication.sv
// Self-checking bench for complex_multiplication: directed scenarios plus
// randomized operand sets against an integer-arithmetic reference.
module tb_complex_multiplication;

  logic       CLK = 1'b0;
  logic       RST;
  logic       data_start;
  logic [3:0] real_a, image_a, real_b, image_b;
  logic [7:0] product_real, product_image;

  int total = 0;
  int bad   = 0;

  complex_multiplication dut (
    .CLK(CLK), .RST(RST), .data_start(data_start),
    .real_a(real_a), .image_a(image_a), .real_b(real_b), .image_b(image_b),
    .product_real(product_real), .product_image(product_image)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_re(logic [3:0] a, logic [3:0] b,
                                         logic [3:0] c, logic [3:0] d);
    int ra, ia, rb, ib;
    ra = $signed(a); ia = $signed(b); rb = $signed(c); ib = $signed(d);
    return 8'(ra * rb - ia * ib);
  endfunction

  function automatic logic [7:0] ref_im(logic [3:0] a, logic [3:0] b,
                                         logic [3:0] c, logic [3:0] d);
    int ra, ia, rb, ib;
    ra = $signed(a); ia = $signed(b); rb = $signed(c); ib = $signed(d);
    return 8'(ra * ib + ia * rb);
  endfunction

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    real_a = a; image_a = b; real_b = c; image_b = d;
  endtask

  // Strobe for one cycle; returns just after the capture edge (at negedge).
  task automatic strobe(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    @(negedge CLK);
    set_ops(a, b, c, d);
    data_start = 1'b1;
    @(negedge CLK);
    data_start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    data_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      set_ops(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      data_start = 1'($urandom);
      #1;
      total++;
      if (product_real !== 8'h00 || product_image !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold: got %h/%h want 00/00", product_real, product_image);
      end
    end
    @(negedge CLK);
    data_start = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      total++;
      if (product_real !== 8'h00 || product_image !== 8'h00) begin
        bad++;
        $display("FAIL reset_release: got %h/%h want 00/00", product_real, product_image);
      end
    end
  endtask

  task automatic test_basic();
    strobe(4'd1, 4'd2, 4'd3, 4'd4);
    for (int e = 1; e <= 4; e++) begin
      @(negedge CLK);
      total++;
      if (product_real !== 8'h00 || product_image !== 8'h00) begin
        bad++;
        $display("FAIL basic_early e%0d: got %h/%h want 00/00", e, product_real, product_image);
      end
    end
    @(negedge CLK);
    total++;
    if (product_real !== 8'hFB || product_image !== 8'h0A) begin
      bad++;
      $display("FAIL basic_result: got %h/%h want fb/0a", product_real, product_image);
    end
  endtask

  task automatic test_extremes();
    strobe(4'h8, 4'h8, 4'h8, 4'h8);
    repeat (5) @(negedge CLK);
    total++;
    if (product_real !== 8'h00 || product_image !== 8'h80) begin
      bad++;
      $display("FAIL extreme_neg8: got %h/%h want 00/80", product_real, product_image);
    end
    strobe(4'd7, 4'h8, 4'd7, 4'd7);
    repeat (5) @(negedge CLK);
    total++;
    if (product_real !== 8'h69 || product_image !== 8'hF9) begin
      bad++;
      $display("FAIL extreme_mix: got %h/%h want 69/f9", product_real, product_image);
    end
  endtask

  task automatic test_isolation();
    strobe(4'd1, 4'd2, 4'd3, 4'd4);
    set_ops(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (5) @(negedge CLK);
    total++;
    if (product_real !== 8'hFB || product_image !== 8'h0A) begin
      bad++;
      $display("FAIL isolation: got %h/%h want fb/0a", product_real, product_image);
    end
  endtask

  task automatic test_restart();
    strobe(4'd1, 4'd1, 4'd1, 4'd1);
    repeat (5) @(negedge CLK);
    total++;
    if (product_real !== 8'h00 || product_image !== 8'h02) begin
      bad++;
      $display("FAIL restart_pre: got %h/%h want 00/02", product_real, product_image);
    end
    strobe(4'd1, 4'd2, 4'd3, 4'd4);
    // now just past edge 0; second strobe lands on edge 2
    @(negedge CLK);
    set_ops(4'd2, 4'd0, 4'd3, 4'd0);
    data_start = 1'b1;
    @(negedge CLK);
    data_start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge CLK);
      total++;
      if (product_real !== 8'h00 || product_image !== 8'h02) begin
        bad++;
        $display("FAIL restart_hold e%0d: got %h/%h want 00/02", e, product_real, product_image);
      end
    end
    @(negedge CLK);
    total++;
    if (product_real !== 8'h06 || product_image !== 8'h00) begin
      bad++;
      $display("FAIL restart_result: got %h/%h want 06/00", product_real, product_image);
    end
  endtask

  task automatic test_mid_reset();
    strobe(4'd3, 4'd3, 4'd3, 4'd3);
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    total++;
    if (product_real !== 8'h00 || product_image !== 8'h00) begin
      bad++;
      $display("FAIL midreset_clear: got %h/%h want 00/00", product_real, product_image);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge CLK);
      total++;
      if (product_real !== 8'h00 || product_image !== 8'h00) begin
        bad++;
        $display("FAIL midreset_lost e%0d: got %h/%h want 00/00", e, product_real, product_image);
      end
    end
    strobe(4'd3, 4'd3, 4'd3, 4'd3);
    repeat (5) @(negedge CLK);
    total++;
    if (product_real !== 8'h00 || product_image !== 8'h12) begin
      bad++;
      $display("FAIL midreset_after: got %h/%h want 00/12", product_real, product_image);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b, c, d;
    logic [7:0] pr, pi;
    pr = product_real;
    pi = product_image;
    @(negedge CLK);
    data_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      set_ops(a, b, c, d);
      @(negedge CLK);
    end
    data_start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge CLK);
      total++;
      if (product_real !== pr || product_image !== pi) begin
        bad++;
        $display("FAIL b2b_hold e%0d: got %h/%h want %h/%h", e, product_real, product_image, pr, pi);
      end
    end
    @(negedge CLK);
    total++;
    if (product_real !== ref_re(a, b, c, d) || product_image !== ref_im(a, b, c, d)) begin
      bad++;
      $display("FAIL b2b_result: got %h/%h want %h/%h", product_real, product_image,
               ref_re(a, b, c, d), ref_im(a, b, c, d));
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b, c, d;
    logic [7:0] pr, pi, er, ei;
    for (int n = 0; n < 1500; n++) begin
      pr = product_real;
      pi = product_image;
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      er = ref_re(a, b, c, d);
      ei = ref_im(a, b, c, d);
      strobe(a, b, c, d);
      for (int e = 1; e <= 4; e++) begin
        set_ops(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        @(negedge CLK);
        if (product_real !== pr || product_image !== pi) begin
          total++;
          bad++;
          $display("FAIL rand_hold n%0d e%0d: got %h/%h want %h/%h", n, e,
                   product_real, product_image, pr, pi);
        end
      end
      @(negedge CLK);
      total++;
      if (product_real !== er || product_image !== ei) begin
        bad++;
        $display("FAIL rand_result n%0d ops %h %h %h %h: got %h/%h want %h/%h", n, a, b, c, d,
                 product_real, product_image, er, ei);
      end
    end
  endtask

  initial begin
    data_start = 1'b0;
    set_ops(4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_basic();
    test_extremes();
    test_isolation();
    test_restart();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
